// File: rtl/s15850_bist_pkg.sv
// Shared constants for the s15850/g10379 BIST slice: PI bit map, LFSR taps, MISR polynomial, FSM states.
// Optional golden compare in the top is enabled with S15850_BIST_GOLDEN_CMP_EN.
package s15850_bist_pkg;

  localparam int LFSR_W = 19;
  localparam int SIG_W  = 16;

  // Cone primary-input positions within pat_out
  localparam int G30_IDX   = 0;
  localparam int G1741_IDX = 18;
  localparam int PI_COUNT  = G1741_IDX - G30_IDX + 1;

  localparam int LFSR_TAP_A = 18;
  localparam int LFSR_TAP_B = 5;
  localparam int LFSR_TAP_C = 1;
  localparam int LFSR_TAP_D = 0;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } bist_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] p);
    logic fb;
    fb = p[LFSR_TAP_A] ^ p[LFSR_TAP_B] ^ p[LFSR_TAP_C] ^ p[LFSR_TAP_D];
    return {p[LFSR_W-2:0], fb};
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic r);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0) ^ {{(SIG_W-1){1'b0}}, r};
  endfunction

endpackage

// File: rtl/s15850_bist_lfsr.sv
// Pattern LFSR: loads the seed (all-zero seed forced to 1) or advances one step per adv_i.
// Load wins over advance; reset also leaves the substituted seed in the register.
module s15850_bist_lfsr
  import s15850_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 19'h00001
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [LFSR_W-1:0] pat_o
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 19'h00001 : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)     lfsr_d = SEED_EFF;
    else if (adv_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= SEED_EFF;
    else          lfsr_q <= lfsr_d;
  end

  assign pat_o = lfsr_q;

endmodule

// File: rtl/s15850_g10379_bist.sv
// BIST wrapper for the g10379 cone: LFSR stimulus, one APPLY + one CAPTURE cycle per vector, MISR signature.
// Define S15850_BIST_GOLDEN_CMP_EN to add the golden-signature comparator and the pass output.
module s15850_g10379_bist
  import s15850_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED         = 19'h00001,
  parameter int                NUM_PATTERNS = 1024
`ifdef S15850_BIST_GOLDEN_CMP_EN
  ,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG   = 16'h0000
`endif
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              start,
  output logic [LFSR_W-1:0] pat_out,
  input  logic              resp_in,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       pat_cnt
`ifdef S15850_BIST_GOLDEN_CMP_EN
  ,
  output logic              pass
`endif
);

  localparam logic [15:0] NP_LAST = 16'(NUM_PATTERNS - 1);
  localparam logic [15:0] NP_MAX  = 16'(NUM_PATTERNS);

  bist_state_e      state_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             busy_q;
  logic             done_q;
  logic             start_acc;
  logic             capture;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign capture   = (state_q == CAPTURE);
  assign sig_d     = misr_next(sig_q, resp_in);
  assign cnt_d     = (cnt_q == NP_MAX) ? cnt_q : cnt_q + 16'd1;

  s15850_bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i   (CK),
    .rst_n_i (RN),
    .load_i  (start_acc),
    .adv_i   (capture),
    .pat_o   (pat_out)
  );

`ifdef S15850_BIST_GOLDEN_CMP_EN
  logic pass_q;
  assign pass = pass_q;
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef S15850_BIST_GOLDEN_CMP_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= APPLY;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef S15850_BIST_GOLDEN_CMP_EN
            pass_q  <= 1'b0;
`endif
          end
        end
        APPLY: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          sig_q <= sig_d;
          cnt_q <= cnt_d;
          if (cnt_q == NP_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef S15850_BIST_GOLDEN_CMP_EN
            pass_q  <= (sig_d == GOLDEN_SIG);
`endif
          end else begin
            state_q <= APPLY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign signature = sig_q;
  assign pat_cnt   = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_s15850_g10379_bist.sv
// Randomized bench for s15850_g10379_bist against an arithmetic model of the LFSR/MISR run rules.
module tb_s15850_g10379_bist;

  localparam int          NP     = 20;
  localparam logic [18:0] SEED   = 19'h00001;
  localparam int          GOLDEN = 16'h000F;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        start = 1'b0;
  logic        resp_in = 1'b0;
  logic [18:0] pat_out;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] pat_cnt;
`ifdef S15850_BIST_GOLDEN_CMP_EN
  logic        pass;
`endif

  s15850_g10379_bist #(
    .SEED         (SEED),
    .NUM_PATTERNS (NP)
`ifdef S15850_BIST_GOLDEN_CMP_EN
    ,
    .GOLDEN_SIG   (16'(GOLDEN))
`endif
  ) dut (
    .CK        (CK),
    .RN        (RN),
    .start     (start),
    .pat_out   (pat_out),
    .resp_in   (resp_in),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .pat_cnt   (pat_cnt)
`ifdef S15850_BIST_GOLDEN_CMP_EN
    ,
    .pass      (pass)
`endif
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  int m_lfsr;
  int m_sig;
  int m_cnt;
  bit resp_pat [NP];
  int exp_ones [4] = '{32'h1, 32'h3, 32'h7, 32'hF};
  int exp_pat  [3] = '{32'h1, 32'h3, 32'h6};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_model(input int p);
    int fb;
    fb = ((p >> 18) ^ (p >> 5) ^ (p >> 1) ^ p) & 1;
    return ((p << 1) | fb) & 32'h7FFFF;
  endfunction

  function automatic int misr_model(input int s, input int r);
    int n;
    n = (s << 1) & 32'hFFFF;
    if ((s >> 15) & 1) n = n ^ 32'h1021;
    return n ^ r;
  endfunction

  task automatic check_all(input string tag, input bit exp_busy, input bit exp_done);
    check_eq({tag, "_pat"},  32'(pat_out),   32'(m_lfsr));
    check_eq({tag, "_sig"},  32'(signature), 32'(m_sig));
    check_eq({tag, "_cnt"},  32'(pat_cnt),   32'(m_cnt));
    check_eq({tag, "_busy"}, 32'(busy),      32'(exp_busy));
    check_eq({tag, "_done"}, 32'(done),      32'(exp_done));
  endtask

  task automatic check_reset(input string tag);
    m_lfsr = SEED; m_sig = 0; m_cnt = 0;
    check_all(tag, 1'b0, 1'b0);
`ifdef S15850_BIST_GOLDEN_CMP_EN
    check_eq({tag, "_pass"}, 32'(pass), 32'd0);
`endif
  endtask

  // Called at posedge+1; returns model signature, or -1 if the run was aborted by reset.
  task automatic run(input int abort_cyc, input bit cap_start, input bit ones_head, output int final_sig);
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    m_lfsr = SEED; m_sig = 0; m_cnt = 0;
    check_all("start", 1'b1, 1'b0);
`ifdef S15850_BIST_GOLDEN_CMP_EN
    check_eq("start_pass", 32'(pass), 32'd0);
`endif
    for (int c = 1; c <= 2 * NP; c++) begin
      resp_in = (c % 2 == 0) ? resp_pat[c/2-1] : 1'($urandom_range(0, 1));
      if (cap_start && c == 6) start = 1'b1;
      @(posedge CK); #1;
      start = 1'b0;
      if (c % 2 == 0) begin
        m_sig  = misr_model(m_sig, int'(resp_pat[c/2-1]));
        m_cnt  = m_cnt + 1;
        m_lfsr = lfsr_model(m_lfsr);
      end
      check_all("run", c < 2 * NP, c == 2 * NP);
      if (c % 2 == 1 && c <= 5)
        check_eq("apply_pat_const", 32'(pat_out), exp_pat[c/2]);
      if (ones_head && c % 2 == 0 && c <= 8)
        check_eq("ones_sig_const", 32'(signature), exp_ones[c/2-1]);
      if (c == abort_cyc) begin
        #2 RN = 1'b0;
        #1 check_reset("abort");
        #1 RN = 1'b1;
        @(posedge CK); #1;
        check_reset("after_abort");
        final_sig = -1;
        return;
      end
    end
    check_eq("done_cnt_const", 32'(pat_cnt), NP);
    for (int h = 0; h < 3; h++) begin
      resp_in = 1'($urandom_range(0, 1));
      @(posedge CK); #1;
      check_all("hold", 1'b0, 1'b1);
`ifdef S15850_BIST_GOLDEN_CMP_EN
      check_eq("hold_pass", 32'(pass), 32'(m_sig == GOLDEN));
`endif
    end
    final_sig = m_sig;
  endtask

  initial begin
    int s_ref;
    int s_tmp;
    RN = 1'b0;
    repeat (2) @(posedge CK);
    #1 check_reset("reset");
    RN = 1'b1;
    @(posedge CK); #1;
    check_reset("idle");

    // First four responses forced to 1, rest random
    for (int i = 0; i < NP; i++) resp_pat[i] = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
    run(0, 1'b0, 1'b1, s_tmp);

    // Random run, then abort mid-run and confirm the restart reproduces the signature
    for (int i = 0; i < NP; i++) resp_pat[i] = 1'($urandom_range(0, 1));
    run(0, 1'b0, 1'b0, s_ref);
    run(21, 1'b0, 1'b0, s_tmp);
    run(0, 1'b0, 1'b0, s_tmp);
    check_eq("restart_sig", 32'(signature), 32'(s_ref));

    // start during CAPTURE must be ignored; following start from DONE restarts
    run(0, 1'b1, 1'b0, s_tmp);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NP; i++) resp_pat[i] = 1'($urandom_range(0, 1));
      run(0, 1'b0, 1'b0, s_tmp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
